// File: rtl/image_op_sequencer.sv
// image_op_sequencer: queues instruction words, issues them one at a time into
// the shared image datapath, waits a fixed latency and holds each result on a
// valid/ready output until it is taken.
// Optional build macro SEQ_PERF_COUNTERS_EN adds perf_issued / perf_stall.

package ImageProcessingPkg;
  typedef enum logic [2:0] {
    OP_NOP = 3'd0,
    OP_ADD = 3'd1,
    OP_SUB = 3'd2,
    OP_MAX = 3'd3,
    OP_MIN = 3'd4
  } opcode_t;

  localparam int MAT_N = 3;
  localparam int PIX_W = 8;

  typedef logic [MAT_N-1:0][MAT_N-1:0][PIX_W-1:0] pixelMatrix_t;

  typedef struct packed {
    opcode_t      opcode;
    pixelMatrix_t cellA;
    pixelMatrix_t cellB;
  } instruction_t;
endpackage

module image_op_sequencer
  import ImageProcessingPkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int OP_LATENCY = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  instruction_t in_iw,
  output logic         in_ready,
  output instruction_t dp_iw,
  output logic         dp_issue,
  input  pixelMatrix_t dp_result,
  output logic         out_valid,
  output pixelMatrix_t out_result,
  output opcode_t      out_opcode,
  input  logic         out_ready,
  output logic         busy
`ifdef SEQ_PERF_COUNTERS_EN
  ,
  output logic [31:0]  perf_issued,
  output logic [31:0]  perf_stall
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [3:0]    wcnt_q, wcnt_d;
  instruction_t  dp_iw_q, dp_iw_d;
  pixelMatrix_t  res_q, res_d;
  opcode_t       opc_q, opc_d;
  instruction_t  mem_q [FIFO_DEPTH];
  logic          push, pop;

  assign in_ready   = (count_q < CW'(FIFO_DEPTH));
  assign push       = in_valid & in_ready;
  // The head is consumed in the single ISSUE cycle; ISSUE is only entered with data queued.
  assign pop        = (state_q == ISSUE);
  assign out_result = res_q;
  assign out_opcode = opc_q;
  assign busy       = (count_q != '0) | (state_q != IDLE);

  // FIFO pointer and occupancy update
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Sequencer next-state, issue and capture
  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    dp_iw_d   = dp_iw_q;
    res_d     = res_q;
    opc_d     = opc_q;
    dp_issue  = 1'b0;
    dp_iw     = dp_iw_q;
    out_valid = (state_q == HOLD);
    case (state_q)
      IDLE: if (count_q != '0) state_d = ISSUE;
      ISSUE: begin
        // The new word is visible to the datapath in the same cycle as the pulse.
        dp_issue = 1'b1;
        dp_iw    = mem_q[rd_ptr_q];
        dp_iw_d  = mem_q[rd_ptr_q];
        wcnt_d   = 4'(OP_LATENCY - 1);
        state_d  = WAIT;
      end
      WAIT: begin
        if (wcnt_q == 4'd0) begin
          res_d   = dp_result;
          opc_d   = dp_iw_q.opcode;
          state_d = HOLD;
        end else begin
          wcnt_d = wcnt_q - 4'd1;
        end
      end
      HOLD: if (out_ready) state_d = (count_q != '0) ? ISSUE : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      wcnt_q   <= '0;
      dp_iw_q  <= '0;
      res_q    <= '0;
      opc_q    <= OP_NOP;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      wcnt_q   <= wcnt_d;
      dp_iw_q  <= dp_iw_d;
      res_q    <= res_d;
      opc_q    <= opc_d;
    end
  end

  // Queue storage; contents need no reset since the pointers define validity
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_iw;
  end

`ifdef SEQ_PERF_COUNTERS_EN
  logic [31:0] issued_q, issued_d, stall_q, stall_d;

  assign perf_issued = issued_q;
  assign perf_stall  = stall_q;

  // Saturating event counters
  always_comb begin
    issued_d = issued_q;
    stall_d  = stall_q;
    if (dp_issue && issued_q != 32'hFFFF_FFFF) issued_d = issued_q + 32'd1;
    if (state_q == HOLD && !out_ready && stall_q != 32'hFFFF_FFFF) stall_d = stall_q + 32'd1;
  end

  // Counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      issued_q <= '0;
      stall_q  <= '0;
    end else begin
      issued_q <= issued_d;
      stall_q  <= stall_d;
    end
  end
`endif

endmodule

// File: tb/tb_image_op_sequencer.sv
// Bench for image_op_sequencer: models the datapath (exact-latency result, junk
// otherwise), tracks expected results in a queue, and runs table vectors, hand
// sequences for the multi-cycle corners and a randomized stretch.
module tb_image_op_sequencer;
  import ImageProcessingPkg::*;

  localparam int DEPTH = 4;
  localparam int LAT   = 1;

  logic         clk = 1'b0;
  logic         rst, in_valid, out_ready;
  instruction_t in_iw, dp_iw;
  logic         in_ready, dp_issue, out_valid, busy;
  pixelMatrix_t dp_result, out_result;
  opcode_t      out_opcode;
`ifdef SEQ_PERF_COUNTERS_EN
  logic [31:0]  perf_issued, perf_stall;
`endif

  always #5 clk = ~clk;

  image_op_sequencer #(.FIFO_DEPTH(DEPTH), .OP_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_iw(in_iw), .in_ready(in_ready),
    .dp_iw(dp_iw), .dp_issue(dp_issue), .dp_result(dp_result),
    .out_valid(out_valid), .out_result(out_result), .out_opcode(out_opcode),
    .out_ready(out_ready), .busy(busy)
`ifdef SEQ_PERF_COUNTERS_EN
    , .perf_issued(perf_issued), .perf_stall(perf_stall)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  task automatic check(string name, logic [127:0] act, logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic pixelMatrix_t alu(instruction_t iw);
    pixelMatrix_t r;
    logic [7:0] a, b;
    for (int i = 0; i < MAT_N; i++)
      for (int j = 0; j < MAT_N; j++) begin
        a = iw.cellA[i][j];
        b = iw.cellB[i][j];
        case (iw.opcode)
          OP_ADD:  r[i][j] = a + b;
          OP_SUB:  r[i][j] = a - b;
          OP_MAX:  r[i][j] = (a > b) ? a : b;
          OP_MIN:  r[i][j] = (a < b) ? a : b;
          default: r[i][j] = a;
        endcase
      end
    return r;
  endfunction

  function automatic pixelMatrix_t fill(logic [7:0] v);
    pixelMatrix_t r;
    for (int i = 0; i < MAT_N; i++)
      for (int j = 0; j < MAT_N; j++) r[i][j] = v;
    return r;
  endfunction

  function automatic instruction_t mk(opcode_t op, pixelMatrix_t a, pixelMatrix_t b);
    instruction_t w;
    w.opcode = op;
    w.cellA  = a;
    w.cellB  = b;
    return w;
  endfunction

  function automatic instruction_t rnd_iw();
    instruction_t w;
    w.opcode = opcode_t'(3'($urandom_range(0, 4)));
    for (int i = 0; i < MAT_N; i++)
      for (int j = 0; j < MAT_N; j++) begin
        w.cellA[i][j] = 8'($urandom);
        w.cellB[i][j] = 8'($urandom);
      end
    return w;
  endfunction

  // Datapath model: correct result only exactly LAT cycles after the issue pulse
  int           dp_cnt;
  instruction_t dp_lat;
  always @(posedge clk) begin
    if (rst) dp_cnt <= 0;
    else if (dp_issue) begin
      dp_cnt <= LAT;
      dp_lat <= dp_iw;
    end else if (dp_cnt != 0) dp_cnt <= dp_cnt - 1;
  end
  assign dp_result = (dp_cnt == 1) ? alu(dp_lat) : {9{8'h5A}};

  // Reference model: occupancy, in-flight flag, expected results in order
  typedef struct {
    opcode_t      op;
    pixelMatrix_t res;
  } exp_t;
  exp_t         exp_q[$];
  exp_t         e;
  int           m_cnt = 0;
  bit           inflight = 0;
  bit           stalled = 0;
  pixelMatrix_t held_r;
  opcode_t      held_o;
  int           issue_cyc[$];
  int           n_out = 0;

  // Mid-cycle monitor: handshakes seen here take effect on the next posedge
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      exp_q.delete();
      issue_cyc.delete();
      m_cnt    = 0;
      inflight = 0;
      stalled  = 0;
      n_out    = 0;
    end else begin
      check("in_ready", in_ready, m_cnt < DEPTH);
      check("busy", busy, (m_cnt != 0) || inflight);
      if (stalled) begin
        check("hold_valid", out_valid, 1);
        check("hold_result", out_result, held_r);
        check("hold_opcode", out_opcode, held_o);
      end
      if (dp_issue) begin
        check("issue_single", inflight, 0);
        issue_cyc.push_back(cyc);
        m_cnt--;
        inflight = 1;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back('{in_iw.opcode, alu(in_iw)});
        m_cnt++;
      end
      if (out_valid && out_ready) begin
        n_out++;
        check("result_pending", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("result", out_result, e.res);
          check("opcode", out_opcode, e.op);
        end
        inflight = 0;
      end
      stalled = out_valid && !out_ready;
      held_r  = out_result;
      held_o  = out_opcode;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(int n);
    rst = 1'b1;
    repeat (n) step();
    rst = 1'b0;
  endtask

  task automatic wait_idle(string name, int bound);
    int k = 0;
    while (k < bound && (busy || exp_q.size() != 0)) begin
      step();
      k++;
    end
    check({name, "_drain_busy"}, busy, 0);
    check({name, "_drain_queue"}, exp_q.size(), 0);
  endtask

  typedef struct {
    opcode_t    op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] pix;
  } vec_t;
  vec_t tbl[6];

  initial begin
    #200000;
    $display("FAIL global_timeout (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    instruction_t iws[6];
    int idx, k, issue_at, out_at, ov_seen;

    tbl[0] = '{OP_ADD, 8'd10,  8'd5,   8'd15};
    tbl[1] = '{OP_SUB, 8'd10,  8'd3,   8'd7};
    tbl[2] = '{OP_MAX, 8'd3,   8'd9,   8'd9};
    tbl[3] = '{OP_MIN, 8'd3,   8'd9,   8'd3};
    tbl[4] = '{OP_ADD, 8'd200, 8'd100, 8'd44};
    tbl[5] = '{OP_SUB, 8'd3,   8'd10,  8'd249};

    // Reset with an offer pending: nothing may be accepted
    rst = 1'b1; in_valid = 1'b1; in_iw = rnd_iw(); out_ready = 1'b1;
    repeat (2) step();
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_dp_issue", dp_issue, 0);
    check("rst_busy", busy, 0);
    check("rst_dp_iw", dp_iw, 0);
    check("rst_out_result", out_result, 0);
    check("rst_out_opcode", out_opcode, 0);
    in_valid = 1'b0; rst = 1'b0;
    step();
    check("post_rst_busy", busy, 0);
    check("post_rst_in_ready", in_ready, 1);

    // Table vectors: one instruction at a time, fixed latency from push
    for (int t = 0; t < 6; t++) begin
      in_valid = 1'b1;
      in_iw = mk(tbl[t].op, fill(tbl[t].a), fill(tbl[t].b));
      step();
      in_valid = 1'b0;
      issue_at = -1; out_at = -1;
      for (int c = 1; c <= 20; c++) begin
        @(negedge clk);
        if (dp_issue && issue_at < 0) issue_at = c;
        if (out_valid) begin
          out_at = c;
          break;
        end
      end
      check("tbl_issue_cycle", issue_at, 2);
      check("tbl_valid_cycle", out_at, LAT + 3);
      check("tbl_result", out_result, fill(tbl[t].pix));
      check("tbl_opcode", out_opcode, tbl[t].op);
      wait_idle("tbl", 20);
    end

    // Backpressure: six stalled cycles with a second instruction waiting
    out_ready = 1'b0;
    in_valid = 1'b1; in_iw = mk(OP_ADD, fill(8'd20), fill(8'd22));
    step();
    in_iw = rnd_iw();
    step();
    in_valid = 1'b0;
    k = 0;
    while (!out_valid && k < 20) begin step(); k++; end
    check("bp_valid_seen", out_valid, 1);
    for (int i = 0; i < 6; i++) begin
      check("bp_valid", out_valid, 1);
      check("bp_stable", out_result, fill(8'd42));
      check("bp_no_issue", dp_issue, 0);
      step();
    end
`ifdef SEQ_PERF_COUNTERS_EN
    check("bp_perf_stall", perf_stall, 6);
`endif
    out_ready = 1'b1;
    wait_idle("bp", 40);

    // Fill: five accepted (four queued plus one issued), sixth held off
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) iws[i] = rnd_iw();
    idx = 0;
    for (int c = 0; c < 10; c++) begin
      in_valid = (idx < 6);
      in_iw = iws[(idx < 6) ? idx : 5];
      @(negedge clk);
      if (in_valid && in_ready) idx++;
      step();
    end
    check("fill_accepted", idx, 5);
    check("fill_in_ready", in_ready, 0);
    out_ready = 1'b1;
    for (int c = 0; c < 40 && idx < 6; c++) begin
      in_valid = 1'b1;
      in_iw = iws[5];
      @(negedge clk);
      if (in_ready) idx++;
      step();
    end
    in_valid = 1'b0;
    check("fill_sixth", idx, 6);
    wait_idle("fill", 60);

    // Wrap: ten streamed instructions at full throughput after a fresh reset
    do_reset(2);
    out_ready = 1'b1;
    idx = 0;
    for (int c = 0; c < 200 && idx < 10; c++) begin
      in_valid = 1'b1;
      in_iw = rnd_iw();
      @(negedge clk);
      if (in_ready) idx++;
      step();
    end
    in_valid = 1'b0;
    wait_idle("wrap", 100);
    check("wrap_results", n_out, 10);
    check("wrap_issues", issue_cyc.size(), 10);
    for (int i = 1; i < issue_cyc.size(); i++)
      check("wrap_spacing", issue_cyc[i] - issue_cyc[i-1], LAT + 2);
`ifdef SEQ_PERF_COUNTERS_EN
    check("wrap_perf_issued", perf_issued, 10);
`endif

    // Reset while the first of three is in WAIT and two are queued
    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_iw = rnd_iw();
      step();
    end
    in_valid = 1'b0;
    check("midrst_busy_before", busy, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_busy_after", busy, 0);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    ov_seen = 0;
    repeat (20) begin
      step();
      if (out_valid) ov_seen++;
    end
    check("midrst_no_result", ov_seen, 0);

    // Randomized traffic with random backpressure
    for (int c = 0; c < 400; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_iw     = rnd_iw();
      out_ready = ($urandom_range(0, 9) < 6);
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    wait_idle("rand", 100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/image_op_sequencer.md
Name: image_op_sequencer

Overview:
- Sequences instruction words into the shared image-processor datapath (ImageProcessingPkg types) and returns each result to the requester.
- Buffers incoming instruction_t words in a small FIFO and issues them one at a time.
- After issue, waits a fixed datapath latency, captures the pixelMatrix_t result and presents it on a valid/ready output.
- Sits between the instruction front end and the ImageProcessor datapath; the only agent allowed to drive the datapath instruction input.

Parameters:
- FIFO_DEPTH, 4, instruction queue depth (power of two, >=2).
- OP_LATENCY, 1, cycles from issue to a valid datapath result (1..15).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- in_valid  in  1  instruction offered.
- in_iw  in  instruction_t  instruction word.
- in_ready  out  1  FIFO has space.
- dp_iw  out  instruction_t  instruction driven to the datapath.
- dp_issue  out  1  one-cycle pulse when dp_iw is newly issued.
- dp_result  in  pixelMatrix_t  datapath result.
- out_valid  out  1  result available.
- out_result  out  pixelMatrix_t  captured result.
- out_opcode  out  opcode field width  opcode of the instruction that produced out_result.
- out_ready  in  1  consumer accepts the result.
- busy  out  1  FIFO non-empty or FSM not IDLE.

Behaviour:
- All state updates on posedge clk.
- rst=1: FIFO emptied (pointers and count 0); FSM -> IDLE; dp_iw=0, dp_issue=0, out_valid=0, out_result=0, out_opcode=0, busy=0.
  - Reset mid-operation discards all queued, in-flight and held work; no result is emitted for it.
- Input handshake:
  - in_ready = (count < FIFO_DEPTH); combinational from count only.
  - Push when in_valid & in_ready.
  - When full, a simultaneous push and pop accepts nothing because in_ready=0. When count < FIFO_DEPTH, push and pop in the same cycle both occur and count is unchanged.
- FSM states: IDLE, ISSUE, WAIT, HOLD.
  - IDLE: if FIFO non-empty -> ISSUE.
  - ISSUE: pop head into dp_iw, assert dp_issue for exactly this cycle, load wait counter with OP_LATENCY-1; -> WAIT. If OP_LATENCY=1, go directly to capture on the next cycle (WAIT lasts one cycle).
  - WAIT: decrement counter. When counter==0, capture dp_result into out_result and dp_iw.opcode into out_opcode, set out_valid=1; -> HOLD.
  - HOLD: out_valid stays high with out_result/out_opcode stable until out_ready=1.
    - On acceptance: out_valid drops next cycle; -> ISSUE if FIFO non-empty (back-to-back), else IDLE.
    - out_ready while out_valid=0 is ignored.
- dp_iw holds the last issued instruction until the next ISSUE; it is zero after reset.
- Throughput: one instruction per (OP_LATENCY+2) cycles with out_ready held high.
- Ordering: strict FIFO; results emerge in issue order.
- FIFO pointers wrap modulo FIFO_DEPTH. Count width is $clog2(FIFO_DEPTH)+1.
- busy = (count != 0) | (state != IDLE).

Optional Feature:
- Macro SEQ_PERF_COUNTERS_EN.
- Defined: adds outputs perf_issued (32-bit; increments on each dp_issue) and perf_stall (32-bit; increments each cycle in HOLD with out_ready=0). Both clear on rst and saturate at 32'hFFFF_FFFF.
- Undefined: neither port nor the counter logic exists; all other behaviour is identical.

Test Plan:
- Reset: drive rst for 2 cycles with in_valid=1 -> in_ready=1, out_valid=0, dp_issue=0, busy=0; FIFO count=0 after release.
- Single ADD, OP_LATENCY=1: push ADD with cellA all pixels=10 and cellB all=5 at cycle 0 -> dp_issue at cycle 2; out_valid at cycle 4 with every pixel=15 and out_opcode=ADD.
- Backpressure: out_ready=0 for 6 cycles after out_valid -> out_result stable; no second dp_issue; perf_stall=6 when SEQ_PERF_COUNTERS_EN is defined.
- Fill: push 5 instructions back-to-back with FIFO_DEPTH=4 and out_ready=0 -> in_ready deasserts after 4 are queued plus 1 issued; the 6th offer is held off; all results emerge in push order.
- Wrap: stream 10 instructions with out_ready=1 -> 10 results in order, one every OP_LATENCY+2 cycles; perf_issued=10.
- Reset mid-WAIT with 2 queued -> no out_valid ever appears for the 3 discarded instructions; busy=0 on the cycle after reset.
